// File: rtl/mux2_arb_pkg.sv
// Shared types and default sizes for the mux2 round-robin arbiter.
package mux2_arb_pkg;

  localparam int unsigned WIDTH_D = 8;
  localparam int unsigned SEL_W_D = 3;
  localparam int unsigned N_REQ_D = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search starting just above the last grant.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] win_oh_c,
  output logic [ID_W-1:0]  win_id_c,
  output logic             any_c
);

  logic [ID_W-1:0] idx;

  // Walk from the farthest candidate back to last+1 so the nearest one wins.
  always_comb begin
    win_oh_c = '0;
    win_id_c = '0;
    idx      = '0;
    any_c    = |req;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      idx = ID_W'((int'(last) + k) % int'(N_REQ));
      if (req[idx]) begin
        win_oh_c      = '0;
        win_oh_c[idx] = 1'b1;
        win_id_c      = idx;
      end
    end
  end

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin sequencer sharing one mux2 datapath between N_REQ requesters,
// returning each captured result on a valid/ready response channel.
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_D,
  parameter int unsigned WIDTH = WIDTH_D,
  parameter int unsigned SEL_W = SEL_W_D,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  input  logic [N_REQ*WIDTH-1:0] req_y,
  input  logic [N_REQ*SEL_W-1:0] req_sel,
  output logic [N_REQ-1:0]   gnt,
  output logic [WIDTH-1:0]   mux_x,
  output logic [WIDTH-1:0]   mux_y,
  output logic [SEL_W-1:0]   mux_sel,
  input  logic [WIDTH-1:0]   mux_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [WIDTH-1:0]   rsp_data
);

  arb_state_t      state;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] cur_id;

  logic [N_REQ-1:0] win_oh_c;
  logic [ID_W-1:0]  win_id_c;
  logic             any_c;
  logic [WIDTH-1:0] pick_x_c;
  logic [WIDTH-1:0] pick_y_c;
  logic [SEL_W-1:0] pick_sel_c;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req      (req),
    .last     (last),
    .win_oh_c (win_oh_c),
    .win_id_c (win_id_c),
    .any_c    (any_c)
  );

  // Select the winner's operands from the packed request buses.
  always_comb begin
    pick_x_c   = '0;
    pick_y_c   = '0;
    pick_sel_c = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (win_oh_c[i]) begin
        pick_x_c   = req_x[i*WIDTH +: WIDTH];
        pick_y_c   = req_y[i*WIDTH +: WIDTH];
        pick_sel_c = req_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  // Grant, issue one cycle to let mux2 settle, then hold the response until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= ID_W'(N_REQ - 1);
      cur_id    <= '0;
      gnt       <= '0;
      mux_x     <= '0;
      mux_y     <= '0;
      mux_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (any_c) begin
            gnt     <= win_oh_c;
            mux_x   <= pick_x_c;
            mux_y   <= pick_y_c;
            mux_sel <= pick_sel_c;
            cur_id  <= win_id_c;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_data  <= mux_out;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          last      <= cur_id;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
